// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: flow controller for the penalty game (SOLO/MULTI).
// It sequences START -> KEEPER/SHOOTER turns -> WINNER/LOSER, gates
// remote starts behind a link-sync window, counts turns, supervises the
// link and registers the sync byte for the UART TX path.
// Optional feature macro: LINK_WATCHDOG_EN. When it is defined, a lost
// link freezes play for up to LINK_TIMEOUT cycles before the match is
// aborted. When it is undefined, the first cycle without a link aborts.

package game_pkg;
  typedef enum logic [2:0] {
    START   = 3'd0,
    KEEPER  = 3'd1,
    SHOOTER = 3'd2,
    WINNER  = 3'd3,
    LOSER   = 3'd4
  } g_state;

  typedef enum logic {
    SOLO  = 1'b0,
    MULTI = 1'b1
  } g_mode;
endpackage

module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int SYNC_CYCLES  = 20,
  parameter int TURN_W       = 4,
  parameter int LINK_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              left_clicked,
  input  logic              right_clicked,
  input  logic              solo_enable,
  input  logic              connect_ok,
  input  logic              enemy_shooter,
  input  logic              game_starts,
  input  logic              end_gk,
  input  logic              end_sh,
  input  logic              match_end,
  input  logic              match_result,
  input  logic              back_to_start,
  output g_state            game_state,
  output g_mode             game_mode,
  output logic [7:0]        data_to_transmit,
  output logic [TURN_W-1:0] turn_cnt,
  output logic              link_lost
);

  localparam int                SYNC_W   = $clog2(SYNC_CYCLES + 1);
  localparam logic [SYNC_W-1:0] SYNC_MAX = SYNC_W'(SYNC_CYCLES);
  localparam logic [TURN_W-1:0] TURN_MAX = '1;

  g_state              state_q, state_d;
  g_mode               mode_q, mode_d;
  logic [7:0]          tx_q, tx_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic                lost_q, lost_d;
  logic [SYNC_W-1:0]   sync_q, sync_d;

  logic in_game_multi;
  logic link_down;
  logic abort;

  // A missing link only matters while a MULTI match is in progress.
  assign in_game_multi = (mode_q == MULTI) &&
                         ((state_q == KEEPER) || (state_q == SHOOTER) ||
                          (state_q == WINNER) || (state_q == LOSER));
  assign link_down     = in_game_multi && !connect_ok;

`ifdef LINK_WATCHDOG_EN
  localparam int              WD_W    = $clog2(LINK_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(LINK_TIMEOUT - 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // The abort fires on the LINK_TIMEOUT-th consecutive low cycle.
  assign abort = link_down && (wd_q == WD_LAST);
  assign wd_d  = (link_down && !abort) ? wd_q + WD_W'(1) : '0;

  // Watchdog counter of consecutive link-low cycles mid-game.
  always_ff @(posedge clk) begin
    if (!rst) wd_q <= '0;
    else      wd_q <= wd_d;
  end
`else
  localparam int link_timeout_unused = LINK_TIMEOUT;

  assign abort = link_down;
`endif

  // Next-state, turn counter, sync window and TX byte selection.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    turn_d  = turn_q;
    lost_d  = 1'b0;
    sync_d  = '0;

    if (left_clicked)       tx_d = 8'hC8;
    else if (right_clicked) tx_d = 8'h28;
    else if (game_starts)   tx_d = 8'h48;
    else                    tx_d = 8'h08;

    if (abort) begin
      state_d = START;
      lost_d  = 1'b1;
    end else if (!link_down) begin
      // While the link is down (watchdog build only) play is frozen.
      case (state_q)
        START: begin
          mode_d = solo_enable ? SOLO : MULTI;
          if (mode_q == SOLO) begin
            if (left_clicked) state_d = KEEPER;
          end else begin
            if (connect_ok)
              sync_d = (sync_q == SYNC_MAX) ? sync_q : sync_q + SYNC_W'(1);
            if (game_starts && (sync_q == SYNC_MAX)) begin
              state_d = enemy_shooter ? SHOOTER : KEEPER;
              sync_d  = '0;
            end
          end
        end
        KEEPER: begin
          if (match_end) begin
            state_d = match_result ? WINNER : LOSER;
          end else if (end_gk) begin
            state_d = SHOOTER;
            if (turn_q != TURN_MAX) turn_d = turn_q + TURN_W'(1);
          end
        end
        SHOOTER: begin
          if (match_end)   state_d = match_result ? WINNER : LOSER;
          else if (end_sh) state_d = KEEPER;
        end
        WINNER, LOSER: begin
          if (right_clicked || (back_to_start && (mode_q == MULTI)))
            state_d = START;
        end
        default: state_d = START;
      endcase
    end

    if (state_d == START) turn_d = '0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= START;
      mode_q  <= MULTI;
      tx_q    <= 8'h08;
      turn_q  <= '0;
      lost_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tx_q    <= tx_d;
      turn_q  <= turn_d;
      lost_q  <= lost_d;
      sync_q  <= sync_d;
    end
  end

  assign game_state       = state_q;
  assign game_mode        = mode_q;
  assign data_to_transmit = tx_q;
  assign turn_cnt         = turn_q;
  assign link_lost        = lost_q;

endmodule
